// File: rtl/mem_access.sv
// MEM-stage access unit: drives loads/stores over a req/ack data bus,
// formats load data and presents the write-back triple to MEM/WB.
module mem_access #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_result,
  input  logic        mem_we,
  input  logic [4:0]  mem_waddr,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_store_data,
  output logic [31:0] wb_result,
  output logic        wb_we,
  output logic [4:0]  wb_waddr,
  output logic        stall_req,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        exc_misalign,
  output logic        exc_bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ABORT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        is_load, is_store, is_mem;
  logic        sz_byte, sz_half, sz_word, misalign;
  logic [1:0]  a_lo;
  logic [3:0]  sel;
  logic [31:0] wdata, ld_data;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign a_lo = mem_result[1:0];

  always_comb begin
    is_load  = (mem_op >= 4'd1) && (mem_op <= 4'd5);
    is_store = (mem_op >= 4'd6) && (mem_op <= 4'd8);
    is_mem   = is_load | is_store;
    sz_byte  = (mem_op == 4'd1) || (mem_op == 4'd2) || (mem_op == 4'd6);
    sz_half  = (mem_op == 4'd3) || (mem_op == 4'd4) || (mem_op == 4'd7);
    sz_word  = (mem_op == 4'd5) || (mem_op == 4'd8);
    misalign = (sz_half && a_lo[0]) || (sz_word && (a_lo != 2'b00));

    sel   = 4'b1111;
    wdata = mem_store_data;
    if (sz_byte) begin
      sel   = 4'b0001 << a_lo;
      wdata = {4{mem_store_data[7:0]}};
    end else if (sz_half) begin
      sel   = a_lo[1] ? 4'b1100 : 4'b0011;
      wdata = {2{mem_store_data[15:0]}};
    end

    case (a_lo)
      2'd0:    byte_v = bus_rdata[7:0];
      2'd1:    byte_v = bus_rdata[15:8];
      2'd2:    byte_v = bus_rdata[23:16];
      default: byte_v = bus_rdata[31:24];
    endcase
    half_v = a_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    case (mem_op)
      4'd1:    ld_data = {{24{byte_v[7]}}, byte_v};
      4'd2:    ld_data = {24'd0, byte_v};
      4'd3:    ld_data = {{16{half_v[15]}}, half_v};
      4'd4:    ld_data = {16'd0, half_v};
      default: ld_data = bus_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wb_result    = mem_result;
    wb_we        = 1'b0;
    wb_waddr     = mem_waddr;
    stall_req    = 1'b0;
    bus_req      = 1'b0;
    bus_we       = 1'b0;
    bus_addr     = {mem_result[31:2], 2'b00};
    bus_sel      = 4'b0000;
    bus_wdata    = 32'd0;
    exc_misalign = is_mem && misalign;
    exc_bus_err  = 1'b0;

    if (state_q == S_ABORT) begin
      // Faulting op leaves EX/MEM on this edge; any ack here is stale.
      exc_bus_err = 1'b1;
      state_d     = S_IDLE;
      cnt_d       = '0;
    end else if (!is_mem) begin
      wb_we   = mem_we;
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (!misalign) begin
      bus_req   = 1'b1;
      bus_we    = is_store;
      bus_sel   = sel;
      bus_wdata = wdata;
      stall_req = !bus_ack;
      if (bus_ack) begin
        if (is_load) begin
          wb_result = ld_data;
          wb_we     = mem_we;
        end
        state_d = S_IDLE;
        cnt_d   = '0;
      end else if (state_q == S_IDLE) begin
        state_d = S_WAIT;
        cnt_d   = CNT_W'(1);
      end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        state_d = S_ABORT;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (!rst) begin
      wb_result    = 32'd0;
      wb_waddr     = 5'd0;
      bus_addr     = 32'd0;
      bus_req      = 1'b0;
      bus_we       = 1'b0;
      bus_sel      = 4'b0000;
      bus_wdata    = 32'd0;
      wb_we        = 1'b0;
      stall_req    = 1'b0;
      exc_misalign = 1'b0;
      exc_bus_err  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios plus randomized transactions
// checked against a transaction-level model of the access rules.
module tb_mem_access;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_result, mem_store_data, bus_rdata;
  logic        mem_we, bus_ack;
  logic [4:0]  mem_waddr;
  logic [3:0]  mem_op;
  logic [31:0] wb_result, bus_addr, bus_wdata;
  logic        wb_we, stall_req, bus_req, bus_we, exc_misalign, exc_bus_err;
  logic [4:0]  wb_waddr;
  logic [3:0]  bus_sel;

  int vecs = 0;
  int errs = 0;

  mem_access #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .mem_result(mem_result), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_op(mem_op), .mem_store_data(mem_store_data),
    .wb_result(wb_result), .wb_we(wb_we), .wb_waddr(wb_waddr),
    .stall_req(stall_req), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .exc_misalign(exc_misalign), .exc_bus_err(exc_bus_err)
  );

  always #5 clk = ~clk;

  // {wb_result, wb_we, wb_waddr, stall, req, bus_we, addr, sel, wdata, mis, err}
  logic [110:0] obs;
  assign obs = {wb_result, wb_we, wb_waddr, stall_req, bus_req, bus_we,
                bus_addr, bus_sel, bus_wdata, exc_misalign, exc_bus_err};

  // ---------------- reference model ----------------
  function automatic int f_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic logic [3:0] f_sel(input logic [3:0] op, input logic [31:0] a);
    int s, off;
    s = f_size(op);
    off = int'(a % 4) - int'(a % 4) % s;
    return 4'(((1 << s) - 1) << off);
  endfunction

  function automatic logic [31:0] f_wdata(input logic [3:0] op, input logic [31:0] sd);
    case (f_size(op))
      1:       return (sd & 32'hFF) * 32'h0101_0101;
      2:       return (sd & 32'hFFFF) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] rd);
    longint v;
    v = longint'(rd >> (8 * (a % 4)));
    case (op)
      4'd1: begin v = v % 256;   return 32'(v >= 128   ? v - 256   : v); end
      4'd2: return 32'(v % 256);
      4'd3: begin v = v % 65536; return 32'(v >= 32768 ? v - 65536 : v); end
      4'd4: return 32'(v % 65536);
      default: return rd;
    endcase
  endfunction

  function automatic logic [110:0] f_exp(
      input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
      input logic [31:0] rd, input logic we, input logic [4:0] wa,
      input logic ack, input logic abort);
    int s;
    logic is_mem, mis, req, st;
    logic [31:0] res;
    logic wwe;
    s = f_size(op);
    is_mem = (s != 0);
    mis = is_mem && (a % s != 0);
    req = is_mem && !mis && !abort;
    st = (op >= 4'd6) && (op <= 4'd8);
    res = a;
    wwe = !is_mem && !abort ? we : 1'b0;
    if (req && ack && !st) begin
      res = f_load(op, a, rd);
      wwe = we;
    end
    return {res, wwe, wa, req && !ack, req, req && st, a & 32'hFFFF_FFFC,
            req ? f_sel(op, a) : 4'd0, req ? f_wdata(op, sd) : 32'd0, mis, abort};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; mem_op = 4'd5; mem_result = 32'h100; mem_we = 1'b1;
    mem_waddr = 5'd9; mem_store_data = 32'h5555_AAAA; bus_ack = 1'b0;
    bus_rdata = 32'hDEAD_BEEF;
    tick(); tick();
    @(negedge clk);
    vecs++;
    if (obs !== '0) begin
      $display("FAIL reset_outputs got=%h want=0", obs); errs++;
    end
    rst = 1'b1; #1;
    vecs++;
    if ({bus_req, stall_req} !== 2'b11) begin
      $display("FAIL reset_release_req got=%b want=11", {bus_req, stall_req}); errs++;
    end
    tick();
    bus_ack = 1'b1;
    @(negedge clk);
    vecs++;
    if ({wb_result, wb_we, stall_req} !== {32'hDEAD_BEEF, 1'b1, 1'b0}) begin
      $display("FAIL reset_first_lw got=%h/%b/%b want=deadbeef/1/0",
               wb_result, wb_we, stall_req); errs++;
    end
    tick();
    bus_ack = 1'b0; mem_op = 4'd0;
  endtask

  task automatic test_passthru();
    mem_op = 4'd0; mem_result = 32'h1234; mem_we = 1'b1; mem_waddr = 5'd7;
    @(negedge clk);
    vecs++;
    if ({wb_result, wb_we, wb_waddr, stall_req, bus_req} !== {32'h1234, 1'b1, 5'd7, 2'b00}) begin
      $display("FAIL passthru got=%h/%b/%0d/%b/%b want=1234/1/7/0/0",
               wb_result, wb_we, wb_waddr, stall_req, bus_req); errs++;
    end
    tick();
  endtask

  task automatic test_lb_wait();
    logic [31:0] want [2];
    want[0] = 32'hFFFF_FF80; want[1] = 32'h0000_0080;
    for (int i = 0; i < 2; i++) begin
      mem_op = (i == 0) ? 4'd1 : 4'd2; mem_result = 32'h103; mem_we = 1'b1;
      mem_waddr = 5'd3; bus_ack = 1'b0; bus_rdata = 32'h1111_1111;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        vecs++;
        if ({bus_sel, stall_req, bus_req, wb_we} !== {4'b1000, 3'b110}) begin
          $display("FAIL lb_wait_c%0d got=%b/%b/%b/%b want=1000/1/1/0",
                   c, bus_sel, stall_req, bus_req, wb_we); errs++;
        end
        tick();
      end
      bus_ack = 1'b1; bus_rdata = 32'h80FF_0000;
      @(negedge clk);
      vecs++;
      if ({wb_result, wb_we, stall_req} !== {want[i], 1'b1, 1'b0}) begin
        $display("FAIL lb_ack_%0d got=%h/%b/%b want=%h/1/0",
                 i, wb_result, wb_we, stall_req, want[i]); errs++;
      end
      tick();
      bus_ack = 1'b0;
    end
    mem_op = 4'd0;
  endtask

  task automatic test_sh_zero();
    mem_op = 4'd7; mem_result = 32'h202; mem_store_data = 32'hABCD_1234;
    mem_we = 1'b1; bus_ack = 1'b1;
    @(negedge clk);
    vecs++;
    if ({bus_addr, bus_sel, bus_wdata, bus_we, wb_we, stall_req} !==
        {32'h200, 4'b1100, 32'h1234_1234, 3'b100}) begin
      $display("FAIL sh_zero got=%h/%b/%h/%b/%b/%b want=200/1100/12341234/1/0/0",
               bus_addr, bus_sel, bus_wdata, bus_we, wb_we, stall_req); errs++;
    end
    tick();
    bus_ack = 1'b0; mem_op = 4'd0;
  endtask

  task automatic test_misalign();
    mem_op = 4'd5; mem_result = 32'h301; bus_ack = 1'b1; mem_we = 1'b1;
    @(negedge clk);
    vecs++;
    if ({exc_misalign, bus_req, wb_we, stall_req} !== 4'b1000) begin
      $display("FAIL misalign_lw got=%b want=1000",
               {exc_misalign, bus_req, wb_we, stall_req}); errs++;
    end
    tick();
    mem_op = 4'd7; mem_result = 32'h203; bus_ack = 1'b0;
    @(negedge clk);
    vecs++;
    if ({exc_misalign, bus_req, wb_we, stall_req} !== 4'b1000) begin
      $display("FAIL misalign_sh got=%b want=1000",
               {exc_misalign, bus_req, wb_we, stall_req}); errs++;
    end
    tick();
  endtask

  // Never-acked SW: exactly TIMEOUT request cycles, then a one-cycle abort
  // with a late ack that must be ignored.
  task automatic test_timeout();
    mem_op = 4'd8; mem_result = 32'h400; mem_store_data = 32'h0BAD_F00D; bus_ack = 1'b0;
    for (int k = 0; k <= TIMEOUT; k++) begin
      if (k == TIMEOUT) bus_ack = 1'b1;
      @(negedge clk);
      vecs++;
      if (k < TIMEOUT) begin
        if ({bus_req, stall_req, exc_bus_err} !== 3'b110) begin
          $display("FAIL timeout_req_c%0d got=%b want=110",
                   k, {bus_req, stall_req, exc_bus_err}); errs++;
        end
      end else if ({bus_req, stall_req, wb_we, exc_bus_err} !== 4'b0001) begin
        $display("FAIL timeout_abort got=%b want=0001",
                 {bus_req, stall_req, wb_we, exc_bus_err}); errs++;
      end
      tick();
    end
    bus_ack = 1'b0; mem_op = 4'd0;
    @(negedge clk);
    vecs++;
    if (exc_bus_err !== 1'b0) begin
      $display("FAIL timeout_err_pulse got=%b want=0", exc_bus_err); errs++;
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    int n;
    mem_op = 4'd5; mem_result = 32'h500; bus_ack = 1'b0;
    repeat (6) tick();
    rst = 1'b0;
    @(negedge clk);
    vecs++;
    if ({bus_req, stall_req} !== 2'b00) begin
      $display("FAIL rst_mid_wait got=%b want=00", {bus_req, stall_req}); errs++;
    end
    tick();
    rst = 1'b1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!bus_req) break;
      n++;
      tick();
    end
    vecs++;
    if (n != TIMEOUT || exc_bus_err !== 1'b1) begin
      $display("FAIL rst_mid_wait_len got=%0d/%b want=%0d/1", n, exc_bus_err, TIMEOUT); errs++;
    end
    tick();
    mem_op = 4'd0;
  endtask

  task automatic test_random();
    logic [3:0]   op;
    logic [31:0]  a, sd, rd;
    logic         we;
    logic [4:0]   wa;
    int           lat, s;
    logic [110:0] e;
    for (int t = 0; t < 60; t++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom; sd = $urandom; rd = $urandom;
      we = 1'($urandom_range(0, 1)); wa = 5'($urandom_range(0, 31));
      lat = $urandom_range(0, 19);
      mem_op = op; mem_result = a; mem_store_data = sd; mem_we = we; mem_waddr = wa;
      s = f_size(op);
      for (int k = 0; k <= TIMEOUT; k++) begin
        if (s == 0 || a % s != 0) begin
          bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
          e = f_exp(op, a, sd, bus_rdata, we, wa, 1'b0, 1'b0);
        end else if (k == TIMEOUT) begin
          bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
          e = f_exp(op, a, sd, bus_rdata, we, wa, bus_ack, 1'b1);
        end else begin
          bus_ack = (k == lat); bus_rdata = (k == lat) ? rd : $urandom;
          e = f_exp(op, a, sd, bus_rdata, we, wa, bus_ack, 1'b0);
        end
        @(negedge clk);
        vecs++;
        if (obs !== e) begin
          $display("FAIL rand_t%0d_c%0d op=%0d a=%h got=%h want=%h", t, k, op, a, obs, e);
          errs++;
        end
        tick();
        if (s == 0 || a % s != 0 || k == lat) break;
      end
      bus_ack = 1'b0;
    end
    mem_op = 4'd0;
  endtask

  initial begin
    mem_op = 4'd0; mem_result = '0; mem_store_data = '0; mem_we = 1'b0;
    mem_waddr = '0; bus_rdata = '0; bus_ack = 1'b0; rst = 1'b0;
    #1;
    test_reset();
    test_passthru();
    test_lb_wait();
    test_sh_zero();
    test_misalign();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
